// File: rtl/bram_nrport_1wport_pkg.sv
// rtl/bram_nrport_1wport_pkg.sv - shared types for the multi-read-port byte-enabled BRAM
package bram_nrport_1wport_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/bram_nrport_1wport_if.sv
// rtl/bram_nrport_1wport_if.sv - read/write port bundle for bram_nrport_1wport
interface bram_nrport_1wport_if #(
   parameter int OUTER_WIDTH = 32,
   parameter int INNER_WIDTH = 32,
   parameter int NUM_RPORTS  = 2
);
   localparam int IDX_W = $clog2(OUTER_WIDTH);
   localparam int NB    = INNER_WIDTH / 8;

   logic [NUM_RPORTS-1:0]                  ren;
   logic [NUM_RPORTS-1:0][IDX_W-1:0]       rindex;
   logic [NUM_RPORTS-1:0]                  rvalid;
   logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] rdata;
   logic [NB-1:0]                          wen_byte;
   logic [IDX_W-1:0]                       windex;
   logic [INNER_WIDTH-1:0]                 wdata;
   logic                                   init_done;

   modport master (
      output ren, rindex, wen_byte, windex, wdata,
      input  rvalid, rdata, init_done
   );

   modport slave (
      input  ren, rindex, wen_byte, windex, wdata,
      output rvalid, rdata, init_done
   );

endinterface

// File: rtl/bram_nrport_1wport_fwd.sv
// rtl/bram_nrport_1wport_fwd.sv - one storage replica with read pipeline and write-first byte bypass
module bram_1rport_1wport_fwd
   import bram_nrport_1wport_pkg::*;
#(
   parameter int OUTER_WIDTH = 32,
   parameter int INNER_WIDTH = 32,
   parameter int OUT_REG     = 0,
   localparam int IDX_W      = $clog2(OUTER_WIDTH),
   localparam int NB         = INNER_WIDTH / BYTE_W
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   re,
   input  logic [IDX_W-1:0]       ridx,
   input  logic [NB-1:0]          we_byte,
   input  logic [IDX_W-1:0]       widx,
   input  logic [INNER_WIDTH-1:0] wdat,
   output logic                   rvalid,
   output logic [INNER_WIDTH-1:0] rdata
);

   logic [INNER_WIDTH-1:0] mem [OUTER_WIDTH];
   logic [INNER_WIDTH-1:0] we_mask;
   logic [INNER_WIDTH-1:0] mem_q;
   logic [INNER_WIDTH-1:0] fwd_dat;
   logic [INNER_WIDTH-1:0] fwd_mask;
   logic [INNER_WIDTH-1:0] stage1;
   logic                   v1;

   always_comb begin
      we_mask = '0;
      for (int b = 0; b < NB; b++)
         we_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{we_byte[b]}};
   end

   always_ff @(posedge CLK) begin
      for (int b = 0; b < NB; b++)
         if (we_byte[b])
            mem[widx][b*BYTE_W +: BYTE_W] <= wdat[b*BYTE_W +: BYTE_W];
   end

   // Array is read-first; the colliding bytes are patched in from the registered write.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1       <= 1'b0;
         mem_q    <= '0;
         fwd_dat  <= '0;
         fwd_mask <= '0;
      end else begin
         v1 <= re;
         if (re) begin
            mem_q    <= mem[ridx];
            fwd_dat  <= wdat;
            fwd_mask <= (ridx == widx) ? we_mask : '0;
         end
      end
   end

   assign stage1 = (mem_q & ~fwd_mask) | (fwd_dat & fwd_mask);

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                   rvalid_q;
         logic [INNER_WIDTH-1:0] rdata_q;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               rvalid_q <= 1'b0;
               rdata_q  <= '0;
            end else begin
               rvalid_q <= v1;
               if (v1)
                  rdata_q <= stage1;
            end
         end
         assign rvalid = rvalid_q;
         assign rdata  = rdata_q;
      end else begin : g_no_out_reg
         assign rvalid = v1;
         assign rdata  = stage1;
      end
   endgenerate

endmodule

// File: rtl/bram_nrport_1wport.sv
// rtl/bram_nrport_1wport.sv - N read port, one byte-enabled write port BRAM with zero-fill sweep
module bram_nrport_1wport
   import bram_nrport_1wport_pkg::*;
#(
   parameter int OUTER_WIDTH = 32,
   parameter int INNER_WIDTH = 32,
   parameter int NUM_RPORTS  = 2,
   parameter int OUT_REG     = 0,
   parameter int INIT_ZERO   = 1
) (
   input logic                CLK,
   input logic                RST,
   bram_nrport_1wport_if.slave bus
);

   localparam int IDX_W = $clog2(OUTER_WIDTH);
   localparam int NB    = INNER_WIDTH / BYTE_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTER_WIDTH - 1);

   state_t                  state, state_n;
   logic [IDX_W-1:0]        cnt, cnt_n;
   logic                    init_done_q;
   logic                    rd_ok;
   logic [NB-1:0]           w_be;
   logic [IDX_W-1:0]        w_idx;
   logic [INNER_WIDTH-1:0]  w_dat;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_INIT;
         cnt         <= '0;
         init_done_q <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         init_done_q <= (state_n == ST_READY);
      end
   end

   // While sweeping, the external write port is muted and the sweep owns the array.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rd_ok   = 1'b0;
      w_be    = '0;
      w_idx   = bus.windex;
      w_dat   = bus.wdata;
      if (state == ST_INIT) begin
         if (INIT_ZERO != 0) begin
            w_be  = '1;
            w_idx = cnt;
            w_dat = '0;
            cnt_n = cnt + 1'b1;
            if (cnt == LAST_IDX)
               state_n = ST_READY;
         end else begin
            state_n = ST_READY;
         end
      end else begin
         rd_ok = 1'b1;
         w_be  = bus.wen_byte;
      end
   end

   assign bus.init_done = init_done_q;

   generate
      for (genvar g = 0; g < NUM_RPORTS; g++) begin : g_port
         bram_1rport_1wport_fwd #(
            .OUTER_WIDTH (OUTER_WIDTH),
            .INNER_WIDTH (INNER_WIDTH),
            .OUT_REG     (OUT_REG)
         ) u_port (
            .CLK     (CLK),
            .RST     (RST),
            .re      (bus.ren[g] & rd_ok),
            .ridx    (bus.rindex[g]),
            .we_byte (w_be),
            .widx    (w_idx),
            .wdat    (w_dat),
            .rvalid  (bus.rvalid[g]),
            .rdata   (bus.rdata[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bram_nrport_1wport.sv
// tb/tb_bram_nrport_1wport.sv - directed bench driving OUT_REG=0 and OUT_REG=1 instances in lockstep
module tb_bram_nrport_1wport;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   logic [1:0]       ren;
   logic [1:0][4:0]  rindex;
   logic [3:0]       wen_byte;
   logic [4:0]       windex;
   logic [31:0]      wdata;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   bram_nrport_1wport_if #(.OUTER_WIDTH(32), .INNER_WIDTH(32), .NUM_RPORTS(2)) bus0 ();
   bram_nrport_1wport_if #(.OUTER_WIDTH(32), .INNER_WIDTH(32), .NUM_RPORTS(2)) bus1 ();

   assign bus0.ren = ren;  assign bus0.rindex = rindex;  assign bus0.wen_byte = wen_byte;
   assign bus0.windex = windex;  assign bus0.wdata = wdata;
   assign bus1.ren = ren;  assign bus1.rindex = rindex;  assign bus1.wen_byte = wen_byte;
   assign bus1.windex = windex;  assign bus1.wdata = wdata;

   bram_nrport_1wport #(.OUTER_WIDTH(32), .INNER_WIDTH(32), .NUM_RPORTS(2), .OUT_REG(0), .INIT_ZERO(1))
      dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
   bram_nrport_1wport #(.OUTER_WIDTH(32), .INNER_WIDTH(32), .NUM_RPORTS(2), .OUT_REG(1), .INIT_ZERO(1))
      dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_write(input logic [4:0] idx, input logic [31:0] dat);
      wen_byte = 4'hF; windex = idx; wdata = dat;
      tick();
      wen_byte = 4'h0;
   endtask

   initial begin
      ren = 2'b00; rindex = '0; wen_byte = 4'h0; windex = '0; wdata = '0;
      #2 RST = 1'b1;
      #1;
      chk("reset rvalid0", 32'(bus0.rvalid), 32'h0);
      chk("reset rdata0p0", bus0.rdata[0], 32'h0);
      chk("reset rdata1p1", bus1.rdata[1], 32'h0);
      chk("reset init_done", 32'({bus0.init_done, bus1.init_done}), 32'h0);
      tick();
      tick();

      // Hammer entry 0 and both read ports during the whole sweep; all must be ignored.
      wen_byte = 4'hF; windex = 5'd0; wdata = 32'hFFFF_FFFF;
      ren = 2'b11;
      RST = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk($sformatf("sweep init_done k=%0d", k), 32'({bus0.init_done, bus1.init_done}),
             (k == 32) ? 32'h3 : 32'h0);
         chk($sformatf("sweep rvalid k=%0d", k), 32'({bus0.rvalid, bus1.rvalid}), 32'h0);
      end
      wen_byte = 4'h0; ren = 2'b00;

      for (int i = 0; i < 32; i++) begin
         ren = 2'b11; rindex[0] = 5'(i); rindex[1] = 5'(31 - i);
         tick();
         chk($sformatf("zero rvalid i=%0d", i), 32'(bus0.rvalid), 32'h3);
         chk($sformatf("zero p0 i=%0d", i), bus0.rdata[0], 32'h0);
         chk($sformatf("zero p1 i=%0d", i), bus0.rdata[1], 32'h0);
         ren = 2'b00;
         tick();
         chk($sformatf("zero oreg p0 i=%0d", i), bus1.rdata[0], 32'h0);
      end

      do_write(5'd5, 32'hDEAD_BEEF);
      ren = 2'b01; rindex[0] = 5'd5;
      tick();
      chk("basic rvalid", 32'(bus0.rvalid), 32'h1);
      chk("basic rdata", bus0.rdata[0], 32'hDEAD_BEEF);
      chk("basic oreg rvalid early", 32'(bus1.rvalid), 32'h0);
      ren = 2'b00;
      tick();
      chk("basic hold rvalid", 32'(bus0.rvalid), 32'h0);
      chk("basic hold rdata", bus0.rdata[0], 32'hDEAD_BEEF);
      chk("basic oreg rvalid", 32'(bus1.rvalid), 32'h1);
      chk("basic oreg rdata", bus1.rdata[0], 32'hDEAD_BEEF);

      do_write(5'd7, 32'h1122_3344);
      wen_byte = 4'b0101; windex = 5'd7; wdata = 32'hAABB_CCDD;
      ren = 2'b11; rindex[0] = 5'd7; rindex[1] = 5'd7;
      tick();
      wen_byte = 4'h0;
      chk("fwd p0", bus0.rdata[0], 32'h11BB_33DD);
      chk("fwd p1", bus0.rdata[1], 32'h11BB_33DD);
      tick();
      chk("after fwd p0", bus0.rdata[0], 32'h11BB_33DD);
      chk("after fwd p1", bus0.rdata[1], 32'h11BB_33DD);
      chk("fwd oreg p0", bus1.rdata[0], 32'h11BB_33DD);
      chk("fwd oreg p1", bus1.rdata[1], 32'h11BB_33DD);
      ren = 2'b00;
      tick();
      chk("after fwd oreg p1", bus1.rdata[1], 32'h11BB_33DD);
      chk("after fwd rvalid", 32'(bus0.rvalid), 32'h0);

      do_write(5'd3, 32'h0000_0003);
      do_write(5'd31, 32'h0000_001F);
      ren = 2'b11; rindex[0] = 5'd3; rindex[1] = 5'd31;
      tick();
      chk("multi p0", bus0.rdata[0], 32'h3);
      chk("multi p1", bus0.rdata[1], 32'h1F);
      ren = 2'b00;
      tick();
      chk("multi idle rvalid", 32'(bus0.rvalid), 32'h0);
      chk("multi hold p0", bus0.rdata[0], 32'h3);
      chk("multi hold p1", bus0.rdata[1], 32'h1F);
      chk("multi oreg rvalid", 32'(bus1.rvalid), 32'h3);
      chk("multi oreg p1", bus1.rdata[1], 32'h1F);

      // Zero byte mask with matching index must not forward wdata.
      wen_byte = 4'h0; windex = 5'd3; wdata = 32'hCAFE_F00D;
      ren = 2'b01; rindex[0] = 5'd3;
      tick();
      chk("nowen fwd", bus0.rdata[0], 32'h3);
      ren = 2'b00;
      tick();

      ren = 2'b10; rindex[1] = 5'd5;
      RST = 1'b1;
      #1;
      chk("rst mid rvalid", 32'({bus0.rvalid, bus1.rvalid}), 32'h0);
      chk("rst mid rdata p0", bus0.rdata[0], 32'h0);
      tick();
      chk("rst held rvalid", 32'({bus0.rvalid, bus1.rvalid}), 32'h0);
      chk("rst held rdata p1", bus0.rdata[1], 32'h0);
      ren = 2'b00;
      RST = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk($sformatf("resweep init_done k=%0d", k), 32'(bus0.init_done), (k == 32) ? 32'h1 : 32'h0);
      end
      ren = 2'b10; rindex[1] = 5'd5;
      tick();
      chk("resweep rvalid", 32'(bus0.rvalid), 32'h2);
      chk("resweep entry5", bus0.rdata[1], 32'h0);
      ren = 2'b00;
      tick();
      chk("resweep oreg entry5", bus1.rdata[1], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
